// File: rtl/tl_arb_pkg.sv
// Shared types and helpers for the beat-locked round-robin channel arbiter.
package tl_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

    localparam int MAX_REQ   = 8;
    localparam int MAX_SRC_W = 3;

    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Scan ptr+1, ptr+2, ... modulo n; return the first requester with valid set.
    function automatic logic [MAX_SRC_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                     input logic [MAX_SRC_W-1:0] ptr,
                                                     input int                   n);
        logic [MAX_SRC_W-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && !found && valid[idx[MAX_SRC_W-1:0]]) begin
                pick  = idx[MAX_SRC_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational rotate-priority encoder: first valid requester after ptr.
module tl_rr_picker
    import tl_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int SRC_W = src_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] sel,
    output logic             any
);

    logic [MAX_REQ-1:0]   valid_w;
    logic [MAX_SRC_W-1:0] ptr_w;
    logic [MAX_SRC_W-1:0] pick;

    always_comb begin
        valid_w              = '0;
        valid_w[N_REQ-1:0]   = valid;
        ptr_w                = '0;
        ptr_w[SRC_W-1:0]     = ptr;
    end

    assign pick = rr_pick(valid_w, ptr_w, N_REQ);
    assign sel  = pick[SRC_W-1:0];
    assign any  = |valid;

endmodule

// File: rtl/tl_beat_rr_arbiter.sv
// Round-robin arbiter for one TileLink-style channel; the grant stays locked
// to a requester until the last beat of its multi-beat message has fired.
module tl_beat_rr_arbiter
    import tl_arb_pkg::*;
#(
    parameter  int N_REQ  = 3,
    parameter  int DATA_W = 32,
    parameter  int BEAT_W = 4,
    localparam int SRC_W  = src_w(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*BEAT_W-1:0] req_beats,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_last,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy
);

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  lock_q, lock_d;
    logic [BEAT_W-1:0] remain_q, remain_d;

    logic [SRC_W-1:0]  sel;
    logic              any;
    logic [SRC_W-1:0]  gidx;
    logic [BEAT_W-1:0] beats_sel;
    logic              fire;

    logic [BEAT_W-1:0] beats_a [N_REQ];
    logic [DATA_W-1:0] data_a  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign beats_a[g] = req_beats[g*BEAT_W +: BEAT_W];
        assign data_a[g]  = req_data[g*DATA_W +: DATA_W];
    end

    tl_rr_picker #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (ptr_q),
        .sel   (sel),
        .any   (any)
    );

    assign gidx      = (state_q == BURST) ? lock_q : sel;
    assign beats_sel = beats_a[sel];

    // Outputs are gated by reset_n so nothing is granted while reset is held.
    always_comb begin
        grant = '0;
        if (reset_n && (state_q == BURST || any)) begin
            grant[gidx] = 1'b1;
        end
    end

    assign out_valid = |(req_valid & grant);
    assign out_data  = data_a[gidx];
    assign out_src   = gidx;
    assign req_ready = out_ready ? grant : '0;
    assign busy      = reset_n && (state_q == BURST);
    assign fire      = out_valid && out_ready;
    assign out_last  = reset_n && ((state_q == IDLE) ? (beats_sel == '0)
                                                     : (remain_q == BEAT_W'(1)));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        lock_d   = lock_q;
        remain_d = remain_q;
        if (fire) begin
            if (state_q == IDLE) begin
                if (beats_sel == '0) begin
                    ptr_d = sel;
                end else begin
                    state_d  = BURST;
                    lock_d   = sel;
                    remain_d = beats_sel;
                end
            end else if (remain_q > BEAT_W'(1)) begin
                remain_d = remain_q - BEAT_W'(1);
            end else begin
                state_d  = IDLE;
                ptr_d    = lock_q;
                remain_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= SRC_W'(N_REQ - 1);
            lock_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            lock_q   <= lock_d;
            remain_q <= remain_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n) begin
            assert ($onehot0(grant))
                else $error("grant is not one-hot-or-zero: %b", grant);
            assert (!busy || grant == ({{(N_REQ-1){1'b0}}, 1'b1} << lock_q))
                else $error("burst grant %b does not match lock %0d", grant, lock_q);
            assert (!fire || $onehot(req_ready))
                else $error("fire with req_ready %b", req_ready);
        end
    end
`endif

endmodule

// File: tb/tb_tl_beat_rr_arbiter.sv
// Directed and random checks of tl_beat_rr_arbiter (N_REQ=3 and N_REQ=5 instances).
module tb_tl_beat_rr_arbiter;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    // N_REQ = 3 instance
    logic [2:0]  v3, rdy3, g3;
    logic [11:0] b3;
    logic [95:0] d3;
    logic        ov3, or3, ol3, busy3;
    logic [31:0] od3;
    logic [1:0]  os3;

    // N_REQ = 5 instance
    logic [4:0]   v5, rdy5, g5;
    logic [19:0]  b5;
    logic [159:0] d5;
    logic         ov5, or5, ol5, busy5;
    logic [31:0]  od5;
    logic [2:0]   os5;

    tl_beat_rr_arbiter #(.N_REQ(3), .DATA_W(32), .BEAT_W(4)) dut3 (
        .clock(clk), .reset_n(reset_n), .req_valid(v3), .req_ready(rdy3),
        .req_beats(b3), .req_data(d3), .out_valid(ov3), .out_ready(or3),
        .out_data(od3), .out_src(os3), .out_last(ol3), .grant(g3), .busy(busy3)
    );

    tl_beat_rr_arbiter #(.N_REQ(5), .DATA_W(32), .BEAT_W(4)) dut5 (
        .clock(clk), .reset_n(reset_n), .req_valid(v5), .req_ready(rdy5),
        .req_beats(b5), .req_data(d5), .out_valid(ov5), .out_ready(or5),
        .out_data(od5), .out_src(os5), .out_last(ol5), .grant(g5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] eg;
        reset_n = 1'b0;
        v3  = 3'b111;
        b3  = '0;
        or3 = 1'b1;
        d3  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if ({g3, ov3, rdy3, busy3, ol3} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got grant=%b valid=%b ready=%b busy=%b last=%b want all zero",
                         g3, ov3, rdy3, busy3, ol3);
            end
            step();
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eg = 3'b001 << (k % 3);
            @(negedge clk);
            n_tests++;
            if (g3 !== eg || os3 !== 2'(k % 3) || ol3 !== 1'b1 || rdy3 !== eg) begin
                n_fail++;
                $display("FAIL reset_priority[%0d]: got grant=%b src=%0d last=%b ready=%b want grant=%b src=%0d last=1",
                         k, g3, os3, ol3, rdy3, eg, k % 3);
            end
            n_tests++;
            if (od3 !== 32'hA000_0000 + 32'(k % 3)) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got %h want %h", k, od3, 32'hA000_0000 + 32'(k % 3));
            end
            step();
        end
        v3 = 3'b000;
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b000 || ov3 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got grant=%b valid=%b want 000/0", g3, ov3);
        end
        step();
    endtask

    task automatic test_burst_lock();
        v3 = 3'b111;
        b3 = {4'd0, 4'd3, 4'd0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (g3 !== 3'b010 || os3 !== 2'd1 || ol3 !== (k == 3) || busy3 !== (k > 0)
                || od3 !== 32'hA000_0001) begin
                n_fail++;
                $display("FAIL burst_beat[%0d]: got grant=%b src=%0d last=%b busy=%b data=%h want 010/1/%0d/%0d/a0000001",
                         k, g3, os3, ol3, busy3, od3, k == 3, k > 0);
            end
            step();
        end
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b100 || busy3 !== 1'b0 || ol3 !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_release: got grant=%b busy=%b last=%b want 100/0/1", g3, busy3, ol3);
        end
        step();
        v3 = 3'b000;
        b3 = '0;
    endtask

    task automatic test_backpressure();
        logic       rdy_seq [4];
        logic [2:0] exp_rdy [4];
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_rdy = '{3'b001, 3'b000, 3'b000, 3'b001};
        v3 = 3'b001;
        b3 = {4'd0, 4'd0, 4'd1};
        for (int k = 0; k < 4; k++) begin
            or3 = rdy_seq[k];
            @(negedge clk);
            n_tests++;
            if (g3 !== 3'b001 || rdy3 !== exp_rdy[k] || busy3 !== (k > 0) || ol3 !== (k > 0)) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got grant=%b ready=%b busy=%b last=%b want 001/%b/%0d/%0d",
                         k, g3, rdy3, busy3, ol3, exp_rdy[k], k > 0, k > 0);
            end
            step();
        end
        v3  = 3'b000;
        or3 = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy3 !== 1'b0 || g3 !== 3'b000) begin
            n_fail++;
            $display("FAIL backpressure_done: got busy=%b grant=%b want 0/000", busy3, g3);
        end
        step();
        b3 = '0;
    endtask

    task automatic test_valid_gap();
        v3 = 3'b101;
        b3 = {4'd3, 4'd0, 4'd0};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (g3 !== 3'b100 || ol3 !== 1'b0 || busy3 !== (k > 0)) begin
                n_fail++;
                $display("FAIL gap_head[%0d]: got grant=%b last=%b busy=%b want 100/0/%0d", k, g3, ol3, busy3, k > 0);
            end
            step();
        end
        v3 = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (ov3 !== 1'b0 || g3 !== 3'b100 || busy3 !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_stall[%0d]: got valid=%b grant=%b busy=%b want 0/100/1", k, ov3, g3, busy3);
            end
            step();
        end
        v3 = 3'b101;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (g3 !== 3'b100 || ov3 !== 1'b1 || ol3 !== (k == 1)) begin
                n_fail++;
                $display("FAIL gap_tail[%0d]: got grant=%b valid=%b last=%b want 100/1/%0d", k, g3, ov3, ol3, k == 1);
            end
            step();
        end
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b001 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_next: got grant=%b busy=%b want 001/0", g3, busy3);
        end
        step();
        v3 = 3'b000;
        b3 = '0;
    endtask

    task automatic test_reset_mid_burst();
        v3 = 3'b010;
        b3 = {4'd0, 4'd6, 4'd0};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (g3 !== 3'b010) begin
                n_fail++;
                $display("FAIL midrst_pre[%0d]: got grant=%b want 010", k, g3);
            end
            step();
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b000 || ov3 !== 1'b0 || busy3 !== 1'b0 || rdy3 !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_hold: got grant=%b valid=%b busy=%b ready=%b want all zero", g3, ov3, busy3, rdy3);
        end
        step();
        reset_n = 1'b1;
        v3 = 3'b011;
        b3 = '0;
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b001 || busy3 !== 1'b0 || ol3 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first: got grant=%b busy=%b last=%b want 001/0/1", g3, busy3, ol3);
        end
        step();
        @(negedge clk);
        n_tests++;
        if (g3 !== 3'b010) begin
            n_fail++;
            $display("FAIL midrst_second: got grant=%b want 010", g3);
        end
        step();
        v3 = 3'b000;
    endtask

    task automatic test_stress();
        int          pend  [5];
        int          left  [5];
        int          waitc [5];
        logic [31:0] dat   [5];
        logic [3:0]  bts   [5];
        int          cur;
        int          s;
        cur = -1;
        for (int i = 0; i < 5; i++) begin
            pend[i] = 0; left[i] = 0; waitc[i] = 0; dat[i] = '0; bts[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 5; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 9) < 4) begin
                    pend[i]  = 1;
                    bts[i]   = 4'($urandom_range(0, 5));
                    left[i]  = int'(bts[i]) + 1;
                    dat[i]   = $urandom;
                    waitc[i] = 0;
                end
                v5[i]           = (pend[i] != 0);
                b5[i*4 +: 4]    = bts[i];
                d5[i*32 +: 32]  = dat[i];
            end
            or5 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_tests++;
            if (!$onehot0(g5)) begin
                n_fail++;
                $display("FAIL stress_onehot[%0d]: got grant=%b want one-hot or zero", cyc, g5);
            end
            if (ov5 && or5) begin
                s = int'(os5);
                n_tests++;
                if (s > 4 || g5 !== (5'b00001 << s) || pend[s] == 0 || (cur >= 0 && s != cur)) begin
                    n_fail++;
                    $display("FAIL stress_grant[%0d]: got src=%0d grant=%b want locked src=%0d with pending request",
                             cyc, s, g5, cur);
                end else begin
                    n_tests++;
                    if (ol5 !== (left[s] == 1)) begin
                        n_fail++;
                        $display("FAIL stress_last[%0d]: got last=%b want %0d (beats left %0d)",
                                 cyc, ol5, left[s] == 1, left[s]);
                    end
                    n_tests++;
                    if (od5 !== dat[s]) begin
                        n_fail++;
                        $display("FAIL stress_data[%0d]: got %h want %h", cyc, od5, dat[s]);
                    end
                    left[s]--;
                    waitc[s] = 0;
                    dat[s]   = $urandom;
                    if (left[s] == 0) begin
                        pend[s] = 0;
                        cur     = -1;
                        for (int j = 0; j < 5; j++) begin
                            if (j != s && pend[j] != 0) begin
                                waitc[j]++;
                                n_tests++;
                                if (waitc[j] > 4) begin
                                    n_fail++;
                                    $display("FAIL stress_starve[%0d]: requester %0d waited %0d messages want <= 4",
                                             cyc, j, waitc[j]);
                                end
                            end
                        end
                    end else begin
                        cur = s;
                    end
                end
            end
            step();
        end
        v5 = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        v3 = '0; b3 = '0; d3 = '0; or3 = 1'b0;
        v5 = '0; b5 = '0; d5 = '0; or5 = 1'b0;
        test_reset();
        test_burst_lock();
        test_backpressure();
        test_valid_gap();
        test_reset_mid_burst();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
